// File: rtl/mips_dmem_responder.sv
`timescale 1ns/1ps
// mips_dmem_responder
// Data-memory responder for the single-cycle MIPS core. Decodes the core's
// word address into a data RAM, a free-running cycle counter and a byte-wide
// output FIFO that drains to an external consumer over valid/ready.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous active-low reset (0 = in reset)
//   memwrite   core write strobe for the current cycle
//   aluout     core byte address (bits [1:0] ignored, word accesses only)
//   writedata  core store data
//   readdata   combinational load data back to the core
//   out_data   FIFO head byte (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer takes the head byte this cycle
module mips_dmem_responder #(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    // Word addresses (byte address >> 2) of the peripheral registers.
    localparam logic [29:0] CNT_WADDR  = 30'h3FFF_C000;
    localparam logic [29:0] STAT_WADDR = 30'h3FFF_C001;
    localparam logic [29:0] TXD_WADDR  = 30'h3FFF_C002;

    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    logic               sel_ram;
    logic               sel_cnt;
    logic               sel_stat;
    logic               sel_txd;
    logic [RAM_AW-1:0]  ram_idx;
    logic [1:0]         unused_byte_off;

    logic [31:0]        ram_q [2**RAM_AW];
    logic [7:0]         fifo_q [FIFO_DEPTH];

    logic [31:0]        cnt_q, cnt_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic [3:0]         stat_cnt;

    // STAT only has room for 4 bits of occupancy; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count(input logic [FIFO_AW:0] c);
        if (32'(c) > 32'd15) begin
            return 4'hF;
        end
        return 4'(c);
    endfunction

    assign unused_byte_off = aluout[1:0];

    assign sel_ram  = (aluout[31:28] == 4'h0);
    assign sel_cnt  = (aluout[31:2] == CNT_WADDR);
    assign sel_stat = (aluout[31:2] == STAT_WADDR);
    assign sel_txd  = (aluout[31:2] == TXD_WADDR);
    assign ram_idx  = aluout[RAM_AW+1:2];

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? fifo_q[rd_ptr_q] : 8'h00;
    assign stat_cnt  = sat_count(count_q);

    // A pop needs a byte already present, so an empty FIFO never falls
    // through; a push into a full FIFO is fine when a pop frees the slot.
    assign pop      = out_valid && out_ready;
    assign push_req = memwrite && sel_txd;
    assign push_ok  = push_req && ((count_q != FULL_COUNT) || pop);

    always_comb begin
        readdata = 32'h0;
        if (sel_ram) begin
            readdata = ram_q[ram_idx];
        end else if (sel_cnt) begin
            readdata = cnt_q;
        end else if (sel_stat) begin
            readdata = {23'b0, ovf_q, 4'b0, stat_cnt};
        end
    end

    always_comb begin
        cnt_d    = (memwrite && sel_cnt) ? writedata : cnt_q + 32'd1;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push_ok) begin
            count_d = count_q - COUNT_ONE;
        end
        // Set wins over clear so a dropped byte is never lost from view.
        ovf_d = (ovf_q && !(memwrite && sel_stat)) || (push_req && !push_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= 32'h0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage arrays carry no reset; emptiness is tracked by count_q.
    always_ff @(posedge clk) begin
        if (memwrite && sel_ram) begin
            ram_q[ram_idx] <= writedata;
        end
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= writedata[7:0];
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
`timescale 1ns/1ps
// tb_mips_dmem_responder
// Scoreboard bench: stimulus queues expected load data and expected FIFO
// bytes; a negedge monitor pops and compares whenever a read is flagged or
// the FIFO hands a byte to the consumer.
module tb_mips_dmem_responder;

    localparam logic [31:0] CNT_A  = 32'hFFFF_0000;
    localparam logic [31:0] STAT_A = 32'hFFFF_0004;
    localparam logic [31:0] TXD_A  = 32'hFFFF_0008;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    typedef struct {
        logic [31:0] exp;
        logic        chk_v;
        logic        exp_v;
        string       name;
    } rd_item_t;

    rd_item_t   rd_q[$];
    logic [7:0] exp_fifo[$];
    logic       rd_chk;
    int         n_cmp;
    int         n_bad;

    mips_dmem_responder #(
        .RAM_AW(10),
        .FIFO_DEPTH(8),
        .FIFO_AW(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .aluout(aluout),
        .writedata(writedata),
        .readdata(readdata),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: compares on the falling edge, away from the active edge.
    rd_item_t mon_it;
    logic [7:0] mon_b;
    always @(negedge clk) begin
        if (rd_chk) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_underflow: read flagged with no expectation queued");
            end else begin
                mon_it = rd_q.pop_front();
                if (readdata !== mon_it.exp) begin
                    n_bad++;
                    $display("FAIL %s: readdata got %h expected %h", mon_it.name, readdata, mon_it.exp);
                end
                if (mon_it.chk_v) begin
                    n_cmp++;
                    if (out_valid !== mon_it.exp_v) begin
                        n_bad++;
                        $display("FAIL %s_valid: out_valid got %b expected %b", mon_it.name, out_valid, mon_it.exp_v);
                    end
                    if (!mon_it.exp_v) begin
                        n_cmp++;
                        if (out_data !== 8'h00) begin
                            n_bad++;
                            $display("FAIL %s_data: out_data got %h expected 00", mon_it.name, out_data);
                        end
                    end
                end
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_fifo.size() == 0) begin
                n_bad++;
                $display("FAIL fifo_extra: unexpected byte %h popped", out_data);
            end else begin
                mon_b = exp_fifo.pop_front();
                if (out_data !== mon_b) begin
                    n_bad++;
                    $display("FAIL fifo_order: out_data got %h expected %h", out_data, mon_b);
                end
            end
        end
    end

    task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic chk, input logic [31:0] exp, input logic cv,
                       input logic ev, input string nm);
        rd_item_t it;
        memwrite  = we;
        aluout    = addr;
        writedata = wd;
        if (chk) begin
            it.exp   = exp;
            it.chk_v = cv;
            it.exp_v = ev;
            it.name  = nm;
            rd_q.push_back(it);
        end
        rd_chk = chk;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        rd_chk   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        cyc(1'b1, addr, wd, 1'b0, 32'h0, 1'b0, 1'b0, "");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        cyc(1'b0, addr, 32'h0, 1'b1, exp, 1'b0, 1'b0, nm);
    endtask

    task automatic rdv(input logic [31:0] addr, input logic [31:0] exp, input logic ev, input string nm);
        cyc(1'b0, addr, 32'h0, 1'b1, exp, 1'b1, ev, nm);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "");
    endtask

    task automatic push(input logic [7:0] b);
        exp_fifo.push_back(b);
        wr(TXD_A, {24'h0, b});
    endtask

    task automatic check_drained(input string nm);
        n_cmp++;
        if (exp_fifo.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected bytes never delivered, expected 0", nm, exp_fifo.size());
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        memwrite  = 1'b0;
        aluout    = 32'h0;
        writedata = 32'h0;
        out_ready = 1'b0;
        rd_chk    = 1'b0;
        @(posedge clk);
        #1;

        // Reset state.
        rdv(CNT_A, 32'h0, 1'b0, "rst_cnt");
        rdv(STAT_A, 32'h0, 1'b0, "rst_stat");

        // Counter after release.
        reset = 1'b1;
        repeat (5) idle();
        rd(CNT_A, 32'd5, "cnt_5");
        wr(CNT_A, 32'hFFFF_FFFE);
        rd(CNT_A, 32'hFFFF_FFFE, "cnt_load");
        rd(CNT_A, 32'hFFFF_FFFF, "cnt_max");
        rd(CNT_A, 32'h0000_0000, "cnt_wrap");

        // RAM, aliasing, same-cycle read-old-data, unmapped space.
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
        rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_byteoff");
        rd(32'h0000_1010, 32'hDEAD_BEEF, "ram_alias");
        cyc(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "ram_rw_old");
        rd(32'h0000_0010, 32'h1234_5678, "ram_rw_new");
        wr(32'h2000_0010, 32'h0000_0BAD);
        rd(32'h0000_0010, 32'h1234_5678, "unmapped_wr");
        rd(32'h1000_0000, 32'h0, "unmapped_rd");
        rd(32'hFFFF_000C, 32'h0, "unmapped_io");
        rd(TXD_A, 32'h0, "txd_rd");

        // FIFO fill, overflow, drain, clear.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
        rdv(STAT_A, 32'h0000_0008, 1'b1, "fill_stat");
        wr(TXD_A, 32'h0000_0049);
        rd(STAT_A, 32'h0000_0108, "ovf_stat");
        out_ready = 1'b1;
        repeat (8) idle();
        rdv(STAT_A, 32'h0000_0100, 1'b0, "drained_stat");
        check_drained("drain1");
        wr(STAT_A, 32'h0);
        rd(STAT_A, 32'h0, "ovf_clear");

        // Full with simultaneous push and pop.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        out_ready = 1'b1;
        push(8'h5A);
        out_ready = 1'b0;
        rdv(STAT_A, 32'h0000_0008, 1'b1, "full_pp_stat");
        out_ready = 1'b1;
        repeat (8) idle();
        rdv(STAT_A, 32'h0, 1'b0, "full_pp_drained");
        check_drained("drain2");

        // Push into an empty FIFO with the consumer ready: no fall-through.
        exp_fifo.push_back(8'h33);
        cyc(1'b1, TXD_A, 32'h0000_0033, 1'b1, 32'h0, 1'b1, 1'b0, "empty_push");
        rdv(STAT_A, 32'h0000_0001, 1'b1, "empty_push_next");
        rdv(STAT_A, 32'h0, 1'b0, "empty_push_popped");
        check_drained("drain3");

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        wr(32'h0000_0020, 32'hCAFE_F00D);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wr(CNT_A, 32'd99);
        rdv(CNT_A, 32'd99, 1'b1, "pre_rst_cnt");
        aluout = CNT_A;
        #2;
        reset = 1'b0;
        exp_fifo.delete();
        begin
            rd_item_t it;
            it.exp   = 32'h0;
            it.chk_v = 1'b1;
            it.exp_v = 1'b0;
            it.name  = "async_rst";
            rd_q.push_back(it);
        end
        rd_chk = 1'b1;
        @(posedge clk);
        #1;
        rd_chk = 1'b0;
        rdv(CNT_A, 32'h0, 1'b0, "in_rst_cnt");
        reset = 1'b1;
        rdv(32'h0000_0020, 32'hCAFE_F00D, 1'b0, "ram_after_rst");
        rd(32'h0000_0010, 32'h1234_5678, "ram_after_rst2");

        n_cmp++;
        if (rd_q.size() != 0) begin
            n_bad++;
            $display("FAIL rd_leftover: %0d read expectations unchecked, expected 0", rd_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
